// File: rtl/cathode_driver.sv
// rtl/cathode_driver.sv - registered hex-to-seven-segment cathode decoder
//
// Decodes one hex nibble into a registered 8-bit cathode pattern.
// Bit 0..6 drive segments A..G and bit 7 drives the decimal point, which
// is always off. The pattern appears one clock after the nibble is sampled.
//
// Ports:
//   clk      - system clock; the output register updates on the rising edge
//   reset    - asynchronous active-low reset; forces the all-off pattern
//   encoded  - hex digit to display, 0x0..0xF
//   segments - registered cathode pattern, polarity set by ACTIVE_LOW
module cathode_driver #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       encoded,
  output logic [WIDTH-1:0] segments
);

  // The segment map is fixed at eight cathodes; other widths cannot be honoured.
  if (WIDTH != 8) begin : g_bad_width
    $error("cathode_driver: WIDTH must be 8");
  end

  localparam logic [WIDTH-1:0] ALL_OFF = {WIDTH{ACTIVE_LOW}};

  logic [7:0]       pattern_al;
  logic [WIDTH-1:0] segments_d;
  logic [WIDTH-1:0] segments_q;

  // Table is written in common-anode form (0 = lit) with DP off in bit 7.
  // Any non-hex value (X/Z in simulation) falls to the all-off default.
  always_comb begin
    pattern_al = 8'hFF;
    case (encoded)
      4'h0:    pattern_al = 8'hC0;
      4'h1:    pattern_al = 8'hF9;
      4'h2:    pattern_al = 8'hA4;
      4'h3:    pattern_al = 8'hB0;
      4'h4:    pattern_al = 8'h99;
      4'h5:    pattern_al = 8'h92;
      4'h6:    pattern_al = 8'h82;
      4'h7:    pattern_al = 8'hF8;
      4'h8:    pattern_al = 8'h80;
      4'h9:    pattern_al = 8'h90;
      4'hA:    pattern_al = 8'h88;
      4'hB:    pattern_al = 8'h83;
      4'hC:    pattern_al = 8'hC6;
      4'hD:    pattern_al = 8'hA1;
      4'hE:    pattern_al = 8'h86;
      4'hF:    pattern_al = 8'h8E;
      default: pattern_al = 8'hFF;
    endcase
  end

  // Common-cathode boards use the same glyphs with every bit inverted,
  // which also turns the all-off default into 0x00.
  always_comb begin
    segments_d = ACTIVE_LOW ? pattern_al : ~pattern_al;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      segments_q <= ALL_OFF;
    end else begin
      segments_q <= segments_d;
    end
  end

  assign segments = segments_q;

endmodule

// File: tb/tb_cathode_driver.sv
// tb/tb_cathode_driver.sv - directed self-checking bench for cathode_driver
module tb_cathode_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] encoded;
  logic [7:0] seg_al;
  logic [7:0] seg_ah;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_tab [16];

  cathode_driver #(.ACTIVE_LOW(1'b1), .WIDTH(8)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .encoded  (encoded),
    .segments (seg_al)
  );

  cathode_driver #(.ACTIVE_LOW(1'b0), .WIDTH(8)) dut_inv (
    .clk      (clk),
    .reset    (rst_n),
    .encoded  (encoded),
    .segments (seg_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a value at the falling edge, then advance to the next falling edge.
  task automatic step(input logic [3:0] v);
    encoded = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    encoded = 4'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (seg_al !== 8'hFF) $display("FAIL reset_hold[%0d]: got %h expected ff", i, seg_al);
      else pass_cnt++;
      total_cnt++;
      if (seg_ah !== 8'h00) $display("FAIL reset_hold_inv[%0d]: got %h expected 00", i, seg_ah);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (seg_al !== 8'hFF) $display("FAIL reset_release_no_edge: got %h expected ff", seg_al);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (seg_al !== 8'h80) $display("FAIL reset_release_8: got %h expected 80", seg_al);
    else pass_cnt++;
    total_cnt++;
    if (seg_ah !== 8'h7F) $display("FAIL reset_release_8_inv: got %h expected 7f", seg_ah);
    else pass_cnt++;
  endtask

  task automatic test_sweep;
    logic [7:0] prev;
    prev = seg_al;
    for (int i = 0; i < 16; i++) begin
      encoded = 4'(i);
      #2;
      total_cnt++;
      if (seg_al !== prev) $display("FAIL sweep_no_edge[%0h]: got %h expected %h", i, seg_al, prev);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (seg_al !== exp_tab[i]) $display("FAIL sweep[%0h]: got %h expected %h", i, seg_al, exp_tab[i]);
      else pass_cnt++;
      total_cnt++;
      if (seg_ah !== ~exp_tab[i]) $display("FAIL sweep_inv[%0h]: got %h expected %h", i, seg_ah, ~exp_tab[i]);
      else pass_cnt++;
      prev = exp_tab[i];
    end
  endtask

  task automatic test_back_to_back;
    step(4'h1);
    total_cnt++;
    if (seg_al !== 8'hF9) $display("FAIL b2b_1: got %h expected f9", seg_al);
    else pass_cnt++;
    step(4'h0);
    total_cnt++;
    if (seg_al !== 8'hC0) $display("FAIL b2b_0: got %h expected c0", seg_al);
    else pass_cnt++;
    step(4'hF);
    total_cnt++;
    if (seg_al !== 8'h8E) $display("FAIL b2b_f: got %h expected 8e", seg_al);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    step(4'h5);
    total_cnt++;
    if (seg_al !== 8'h92) $display("FAIL async_pre_5: got %h expected 92", seg_al);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (seg_al !== 8'hFF) $display("FAIL async_assert: got %h expected ff", seg_al);
    else pass_cnt++;
    total_cnt++;
    if (seg_ah !== 8'h00) $display("FAIL async_assert_inv: got %h expected 00", seg_ah);
    else pass_cnt++;
    encoded = 4'h3;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (seg_al !== 8'hFF) $display("FAIL async_held_over_edge: got %h expected ff", seg_al);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (seg_al !== 8'hFF) $display("FAIL async_release_no_edge: got %h expected ff", seg_al);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (seg_al !== 8'hB0) $display("FAIL async_release_3: got %h expected b0", seg_al);
    else pass_cnt++;
  endtask

  task automatic test_polarity;
    step(4'h0);
    total_cnt++;
    if (seg_ah !== 8'h3F) $display("FAIL polarity_0: got %h expected 3f", seg_ah);
    else pass_cnt++;
    step(4'h7);
    total_cnt++;
    if (seg_ah !== 8'h07) $display("FAIL polarity_7: got %h expected 07", seg_ah);
    else pass_cnt++;
  endtask

  task automatic test_x_input;
    logic [3:0] xv;
    logic [7:0] exp_x;
    xv = 4'bx1x0;
    encoded = xv;
    #1;
    // A two-state simulator resolves the X bits to a concrete nibble; in
    // that case the register must hold that nibble's glyph instead.
    if ($isunknown(encoded)) exp_x = 8'hFF;
    else exp_x = exp_tab[encoded];
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (seg_al !== exp_x) $display("FAIL x_input: got %h expected %h", seg_al, exp_x);
    else pass_cnt++;
    step(4'hA);
    total_cnt++;
    if (seg_al !== 8'h88) $display("FAIL x_then_a: got %h expected 88", seg_al);
    else pass_cnt++;
  endtask

  initial begin
    exp_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst_n   = 1'b0;
    encoded = 4'h0;
    test_reset;
    test_sweep;
    test_back_to_back;
    test_async_reset;
    test_polarity;
    test_x_input;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cathode_driver.md
Name: cathode_driver

Overview:
Registered hex-to-seven-segment cathode decoder. It converts one 4-bit nibble into an 8-bit cathode pattern: segments A–G plus the decimal point. One instance serves each digit of the multiplexed display controller. That controller selects which instance's output drives the shared cathode bus for the currently enabled anode.

Parameters:
- ACTIVE_LOW, default 1: cathode polarity. 1 means a segment is lit when its bit is 0, matching common-anode boards. 0 means a segment is lit when its bit is 1.
- WIDTH, default 8: cathode output width. Only 8 is supported; any other value is an elaboration error.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- encoded, input, 4: hex digit to display, 0x0–0xF.
- segments, output, 8 (WIDTH): registered cathode pattern.
  - Bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = D, bit 4 = E, bit 5 = F, bit 6 = G, bit 7 = DP.

Behaviour:
- Reset:
  - While reset = 0, segments is forced immediately, independent of clk, to the all-off pattern.
  - All-off is 0xFF when ACTIVE_LOW = 1 and 0x00 when ACTIVE_LOW = 0.
  - Release is synchronous in effect: the first rising edge after reset returns to 1 loads the decode of encoded.
- Latency:
  - Exactly one clock. The value of encoded sampled at rising edge N appears on segments after edge N.
  - No combinational path exists from encoded to segments.
  - A new value may be presented every cycle; no handshake.
- Decimal point: always off. Bit 7 = 1 when ACTIVE_LOW = 1, 0 when ACTIVE_LOW = 0.
- Decode table, ACTIVE_LOW = 1, full byte including DP-off:
  - 0→0xC0, 1→0xF9, 2→0xA4, 3→0xB0
  - 4→0x99, 5→0x92, 6→0x82, 7→0xF8
  - 8→0x80, 9→0x90, A→0x88, b→0x83
  - C→0xC6, d→0xA1, E→0x86, F→0x8E
  - Glyphs: uppercase A, C, E, F; lowercase b, d. The 6 glyph includes the top segment; 7 is A, B, C only; 9 includes segment D.
- ACTIVE_LOW = 0: output is the bitwise inverse of the table above (e.g. 0→0x3F, 8→0x7F).
- Unknown or X on encoded: the register loads the all-off pattern.
  - The decode default branch is mandatory; every case item is fully specified.
- Reset asserted mid-stream: output goes to all-off within the same delta, regardless of pending edges.
  - No residual digit is shown after release until the next edge.
- No other state, counters or enables. Output holds its value between edges while encoded is stable.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with encoded = 4'h8 → segments = 0xFF throughout. Release; after the next rising edge → 0x80.
- Exhaustive sweep, ACTIVE_LOW = 1: drive encoded 0x0..0xF, one per cycle → each table value appears exactly one cycle after its input (e.g. 0x2 → 0xA4, 0xd → 0xA1). No output change occurs without a clock edge.
- Back-to-back changes: encoded toggles 0x1 → 0x0 → 0xF on consecutive edges → segments = 0xF9, 0xC0, 0x8E on the following edges. Verifies single-cycle latency and no skipped values.
- Async reset mid-operation: encoded = 0x5, segments = 0x92; pull reset low between edges → segments = 0xFF immediately, before the next edge. Release with encoded = 0x3 → 0xB0 after the next edge.
- Polarity: with ACTIVE_LOW = 0, encoded = 0x0 → 0x3F; 0x7 → 0x07; during reset → 0x00.
- X input: encoded = 4'bx1x0 → segments = 0xFF after the next edge. Valid 0xA afterwards → 0x88.
